// File: rtl/div4_seq.sv
// Multi-cycle restoring unsigned divider, one quotient bit per clock.
// Ports: clk, reset (sync, active-high), start, A/B in; Q/R/busy/done/div_zero out.
module div4_seq #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dz_q, dz_d;

    logic [WIDTH-1:0] rem_shift;
    logic [WIDTH:0]   trial;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        q_d     = q_q;
        r_d     = r_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dz_d    = dz_q;

        // Partial remainder never exceeds WIDTH-1 significant bits before a
        // shift, so dropping its MSB here loses nothing.
        rem_shift = {rem_q[WIDTH-2:0], dvd_q[WIDTH-1]};
        // Extra MSB acts as the borrow: 1 means the trial went negative.
        trial = {1'b0, rem_shift} - {1'b0, dvs_q};

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    dvd_d   = A;
                    dvs_d   = B;
                    rem_d   = '0;
                    quo_d   = '0;
                    cnt_d   = CW'(WIDTH);
                    state_d = RUN;
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            RUN: begin
                dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
                if (!trial[WIDTH]) begin
                    rem_d = trial[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = rem_shift;
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    q_d     = quo_d;
                    r_d     = rem_d;
                    dz_d    = (dvs_q == '0);
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            q_q     <= q_d;
            r_q     <= r_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

    assign Q        = q_q;
    assign R        = r_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = dz_q;

endmodule

// File: tb/tb_div4_seq.sv
// Self-checking bench for div4_seq: directed cases then random operations.
// Expected results come from plain integer division in the bench.
module tb_div4_seq;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] A, B;
    logic [W-1:0] Q, R;
    logic         busy, done, div_zero;

    int n_chk = 0;
    int n_fail = 0;

    logic [W-1:0] pq, pr;
    logic         pz;

    div4_seq #(.WIDTH(W)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .A(A),
        .B(B),
        .Q(Q),
        .R(R),
        .busy(busy),
        .done(done),
        .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic go(input int a, input int b);
        A = W'(a);
        B = W'(b);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Follows an accepted op through busy and done. glitch selects a busy
    // cycle in which a stray start is driven; b2b issues the next op in the
    // done cycle.
    task automatic await_done(input int a, input int b, input int glitch,
                              input bit b2b, input int na, input int nb);
        int eq, er;
        bit ez;
        ez = (b == 0);
        eq = ez ? (1 << W) - 1 : a / b;
        er = ez ? a : a % b;
        for (int i = 0; i < W; i++) begin
            chk("busy_run", int'(busy), 1);
            chk("done_run", int'(done), 0);
            chk("q_hold_run", int'(Q), int'(pq));
            chk("r_hold_run", int'(R), int'(pr));
            chk("dz_hold_run", int'(div_zero), int'(pz));
            start = (i == glitch);
            A = W'($urandom);
            B = W'($urandom);
            tick();
        end
        start = 1'b0;
        chk("done_pulse", int'(done), 1);
        chk("busy_done", int'(busy), 0);
        chk("q_res", int'(Q), eq);
        chk("r_res", int'(R), er);
        chk("dz_res", int'(div_zero), int'(ez));
        pq = W'(eq);
        pr = W'(er);
        pz = ez;
        if (b2b) begin
            A = W'(na);
            B = W'(nb);
            start = 1'b1;
            tick();
            start = 1'b0;
        end else begin
            tick();
            chk("done_low", int'(done), 0);
            chk("busy_idle", int'(busy), 0);
            chk("q_hold_idle", int'(Q), int'(pq));
            chk("r_hold_idle", int'(R), int'(pr));
        end
    endtask

    initial begin
        int a, b, na, nb, g;
        bit bb;
        reset = 1'b1;
        start = 1'b0;
        A = '0;
        B = '0;
        pq = '0;
        pr = '0;
        pz = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_q", int'(Q), 0);
        chk("rst_r", int'(R), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_dz", int'(div_zero), 0);

        go(13, 3);
        await_done(13, 3, 9, 0, 0, 0);
        go(15, 1);
        await_done(15, 1, 9, 0, 0, 0);
        go(3, 7);
        await_done(3, 7, 9, 0, 0, 0);
        repeat (3) begin
            tick();
            chk("q_hold_long", int'(Q), 0);
            chk("r_hold_long", int'(R), 3);
            chk("done_quiet", int'(done), 0);
        end

        go(9, 0);
        await_done(9, 0, 9, 0, 0, 0);
        go(8, 2);
        await_done(8, 2, 9, 0, 0, 0);

        go(12, 5);
        await_done(12, 5, 1, 0, 0, 0);
        repeat (W + 2) begin
            tick();
            chk("no_second_done", int'(done), 0);
            chk("no_second_busy", int'(busy), 0);
        end

        go(6, 4);
        await_done(6, 4, 9, 1, 14, 4);
        await_done(14, 4, 9, 0, 0, 0);

        go(13, 3);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        pq = '0;
        pr = '0;
        pz = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_q", int'(Q), 0);
        chk("abort_r", int'(R), 0);
        chk("abort_dz", int'(div_zero), 0);
        repeat (W + 2) begin
            chk("abort_no_done", int'(done), 0);
            tick();
        end
        go(13, 3);
        await_done(13, 3, 9, 0, 0, 0);

        a = int'($urandom_range(0, (1 << W) - 1));
        b = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, (1 << W) - 1));
        go(a, b);
        for (int k = 0; k < 30; k++) begin
            na = int'($urandom_range(0, (1 << W) - 1));
            nb = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, (1 << W) - 1));
            bb = 1'($urandom_range(0, 1));
            g = int'($urandom_range(0, W + 1));
            await_done(a, b, g, bb, na, nb);
            if (!bb) begin
                repeat ($urandom_range(0, 2)) tick();
                go(na, nb);
            end
            a = na;
            b = nb;
        end
        await_done(a, b, 9, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
